// File: rtl/fill_pkg.sv
// Shared types and resolution presets for the rectangle fill engine.
package fill_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        COLS    = 2'd1,
        ROWS    = 2'd2,
        CHECKER = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // 160x120 matches the original lab adapter; 320x240 is the larger build.
    localparam int H_RES_160 = 160;
    localparam int V_RES_120 = 120;
    localparam int XW_160    = 8;
    localparam int YW_120    = 7;

    localparam int H_RES_320 = 320;
    localparam int V_RES_240 = 240;
    localparam int XW_320    = 9;
    localparam int YW_240    = 8;

endpackage

// File: rtl/fill_pattern.sv
// Combinational pixel colour generator for the four fill modes.
module fill_pattern
    import fill_pkg::*;
#(
    parameter int CW       = 3,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CHK_LOG2 = 3
) (
    input  fill_mode_e      mode,
    input  logic [CW-1:0]   colour,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    output logic [CW-1:0]   pixel
);

    // Only low coordinate bits feed the patterns.
    logic unused_xy;
    assign unused_xy = ^{x, y};

    always_comb begin
        pixel = colour;
        case (mode)
            SOLID:   pixel = colour;
            COLS:    pixel = x[CW-1:0];
            ROWS:    pixel = y[CW-1:0];
            CHECKER: pixel = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? ~colour : colour;
            default: pixel = colour;
        endcase
    end

endmodule

// File: rtl/fill_engine.sv
// Rasters a clipped rectangle into the VGA adapter, one pixel per clock,
// column-major (y fastest), with start/done handshake.
module fill_engine #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3,
    parameter int CHK_LOG2 = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   colour,
    input  logic [XW-1:0]   x0,
    input  logic [YW-1:0]   y0,
    input  logic [XW-1:0]   x1,
    input  logic [YW-1:0]   y1,
    output logic            busy,
    output logic            done,
    output logic [XW-1:0]   vga_x,
    output logic [YW-1:0]   vga_y,
    output logic [CW-1:0]   vga_colour,
    output logic            vga_plot
);

    import fill_pkg::*;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    fill_state_e     state, state_nxt;
    logic [XW-1:0]   cur_x, cur_x_nxt;
    logic [YW-1:0]   cur_y, cur_y_nxt;
    logic [XW-1:0]   lx1;
    logic [YW-1:0]   ly0, ly1;
    fill_mode_e      lmode, mode_nxt;
    logic [CW-1:0]   lcol, col_nxt;
    logic [CW-1:0]   pix_nxt;
    logic            load;

    logic [XW-1:0]   clip_x1;
    logic [YW-1:0]   clip_y1;
    logic            empty;

    assign clip_x1 = (x1 > X_LAST) ? X_LAST : x1;
    assign clip_y1 = (y1 > Y_LAST) ? Y_LAST : y1;
    assign empty   = (x0 > clip_x1) || (y0 > clip_y1);

    always_comb begin
        state_nxt = state;
        cur_x_nxt = cur_x;
        cur_y_nxt = cur_y;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cur_x_nxt = x0;
                    cur_y_nxt = y0;
                    state_nxt = empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (cur_y == ly1) begin
                    cur_y_nxt = ly0;
                    if (cur_x == lx1) begin
                        state_nxt = DONE;
                    end else begin
                        cur_x_nxt = cur_x + XW'(1);
                    end
                end else begin
                    cur_y_nxt = cur_y + YW'(1);
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Colour for the pixel that will be on the bus next cycle; on the
    // IDLE->FILL edge the latches are not loaded yet, so take the inputs.
    assign mode_nxt = load ? fill_mode_e'(mode) : lmode;
    assign col_nxt  = load ? colour : lcol;

    fill_pattern #(
        .CW       (CW),
        .XW       (XW),
        .YW       (YW),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .mode   (mode_nxt),
        .colour (col_nxt),
        .x      (cur_x_nxt),
        .y      (cur_y_nxt),
        .pixel  (pix_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x      <= '0;
            cur_y      <= '0;
            lx1        <= '0;
            ly0        <= '0;
            ly1        <= '0;
            lmode      <= SOLID;
            lcol       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            cur_x <= cur_x_nxt;
            cur_y <= cur_y_nxt;
            if (load) begin
                lx1   <= clip_x1;
                ly0   <= y0;
                ly1   <= clip_y1;
                lmode <= fill_mode_e'(mode);
                lcol  <= colour;
            end
            busy     <= (state_nxt == FILL);
            done     <= (state_nxt == DONE);
            vga_plot <= (state_nxt == FILL);
            if (state_nxt == FILL) begin
                vga_x      <= cur_x_nxt;
                vga_y      <= cur_y_nxt;
                vga_colour <= pix_nxt;
            end else begin
                vga_x      <= '0;
                vga_y      <= '0;
                vga_colour <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fill_engine.sv
// Self-checking bench for fill_engine: cycle-exact plot stream against a
// rectangle/pattern reference model, directed cases plus random rectangles.
module tb_fill_engine;

    logic        CLOCK_50;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  colour;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic        busy, done, vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int n_chk;
    int n_pass;
    logic [19:0] exp_q[$];

    fill_engine #(
        .H_RES(160), .V_RES(120), .XW(8), .YW(7), .CW(3), .CHK_LOG2(3)
    ) dut (
        .clk        (CLOCK_50),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .colour     (colour),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: every pixel of the clipped rectangle, x outer, y inner,
    // packed as {plot, busy, x, y, colour}.
    function automatic void build(input int md, input int c, input int ax0,
                                  input int ay0, input int ax1, input int ay1);
        int ex1, ey1, p;
        logic [7:0] xb;
        logic [6:0] yb;
        logic [2:0] pb;
        exp_q.delete();
        ex1 = (ax1 > 159) ? 159 : ax1;
        ey1 = (ay1 > 119) ? 119 : ay1;
        for (int x = ax0; x <= ex1; x++) begin
            for (int y = ay0; y <= ey1; y++) begin
                case (md)
                    0: p = c;
                    1: p = x % 8;
                    2: p = y % 8;
                    default: p = (((x / 8) + (y / 8)) % 2 == 1) ? (7 - c) : c;
                endcase
                xb = x[7:0];
                yb = y[6:0];
                pb = p[2:0];
                exp_q.push_back({2'b11, xb, yb, pb});
            end
        end
    endfunction

    task automatic scramble_inputs();
        mode   = 2'($urandom);
        colour = 3'($urandom);
        x0     = 8'($urandom);
        y0     = 7'($urandom);
        x1     = 8'($urandom);
        y1     = 7'($urandom);
    endtask

    task automatic run_fill(input string tag, input int md, input int c,
                            input int ax0, input int ay0, input int ax1, input int ay1,
                            input int hold, input bit scram);
        int n;
        build(md, c, ax0, ay0, ax1, ay1);
        n = exp_q.size();
        @(negedge CLOCK_50);
        mode   = 2'(md);
        colour = 3'(c);
        x0     = 8'(ax0);
        y0     = 7'(ay0);
        x1     = 8'(ax1);
        y1     = 7'(ay1);
        start  = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge CLOCK_50);
            chk({tag, "_pix"}, {12'd0, vga_plot, busy, vga_x, vga_y, vga_colour}, {12'd0, exp_q[k]});
            if (scram) scramble_inputs();
        end
        @(negedge CLOCK_50);
        chk({tag, "_done"}, {29'd0, done, busy, vga_plot}, 32'b100);
        for (int h = 0; h < hold; h++) begin
            @(negedge CLOCK_50);
            chk({tag, "_hold"}, {29'd0, done, busy, vga_plot}, 32'b100);
        end
        start = 1'b0;
        @(negedge CLOCK_50);
        chk({tag, "_idle"}, {29'd0, done, busy, vga_plot}, 32'b000);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b0;
        mode   = '0;
        colour = '0;
        x0     = '0;
        y0     = '0;
        x1     = '0;
        y1     = '0;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_out", {11'd0, busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
        rst = 1'b0;

        run_fill("solid_full", 0, 5, 0, 0, 159, 119, 2, 1'b1);
        run_fill("cols_full", 1, 0, 0, 0, 159, 119, 1, 1'b0);
        run_fill("checker", 3, 2, 4, 4, 11, 11, 1, 1'b1);
        run_fill("clip", 2, 6, 150, 110, 200, 127, 1, 1'b1);
        run_fill("empty_x", 0, 3, 170, 0, 180, 10, 1, 1'b0);
        run_fill("empty_y", 1, 3, 0, 50, 10, 40, 0, 1'b0);
        run_fill("max_x1", 3, 7, 155, 115, 255, 127, 1, 1'b0);
        run_fill("handshake", 3, 4, 20, 30, 27, 33, 50, 1'b0);
        run_fill("refill", 2, 1, 100, 0, 103, 9, 1, 1'b0);

        // Reset during a fill, then a complete fill of the same region.
        build(3, 6, 10, 5, 60, 40);
        @(negedge CLOCK_50);
        mode   = 2'd3;
        colour = 3'd6;
        x0     = 8'd10;
        y0     = 7'd5;
        x1     = 8'd60;
        y1     = 7'd40;
        start  = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge CLOCK_50);
            chk("pre_rst_pix", {12'd0, vga_plot, busy, vga_x, vga_y, vga_colour}, {12'd0, exp_q[k]});
        end
        rst   = 1'b1;
        start = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_mid_out", {11'd0, busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
        rst = 1'b0;
        @(negedge CLOCK_50);
        chk("rst_idle_out", {11'd0, busy, done, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
        run_fill("post_rst", 3, 6, 10, 5, 60, 40, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rx0 = $urandom_range(0, 175);
            ry0 = $urandom_range(0, 127);
            rx1 = rx0 + $urandom_range(0, 20);
            ry1 = ry0 + $urandom_range(0, 20);
            if ($urandom_range(0, 5) == 0 && rx0 > 0) rx1 = rx0 - 1;
            if (rx1 > 255) rx1 = 255;
            if (ry1 > 127) ry1 = 127;
            run_fill("rand", $urandom_range(0, 3), $urandom_range(0, 7),
                     rx0, ry0, rx1, ry1, $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
